// File: rtl/alu_lockstep_sched.sv
// alu_lockstep_sched: round-robin scheduler issuing ops to a dual-copy 4-bit ALU in lockstep and flagging copy mismatches.
// Define ALU_FAULT_INJECT_EN to add inject_i, which flips bit 0 of copy-1's operand A for one op.
module alu_lockstep_sched #(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1,
  parameter int FCNT_W  = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
`ifdef ALU_FAULT_INJECT_EN
  input  logic                inject_i,
`endif
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [4*NREQ-1:0]   req_a_i,
  input  logic [4*NREQ-1:0]   req_b_i,
  input  logic [2*NREQ-1:0]   req_sel_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [1:0]          resp_id_o,
  output logic [3:0]          resp_result_o,
  output logic                resp_carry_o,
  output logic                resp_fault_o,
  output logic [3:0]          alu_a0_o,
  output logic [3:0]          alu_b0_o,
  output logic [3:0]          alu_a1_o,
  output logic [3:0]          alu_b1_o,
  output logic [1:0]          alu_sel1_o,
  output logic [1:0]          alu_sel2_o,
  input  logic [3:0]          alu_out1_i,
  input  logic [3:0]          alu_out2_i,
  input  logic                alu_carry1_i,
  input  logic                alu_carry2_i,
  input  logic                fault_clr_i,
  output logic [FCNT_W-1:0]   fault_cnt_o,
  output logic                irq_o
);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, RESP} state_t;
  state_t      state;
  logic [1:0]  rst_sync;
  logic        rst_n;
  logic [1:0]  ptr;
  logic [1:0]  gnt;
  logic [2:0]  idx;
  logic [2:0]  cnt;
  logic        gnt_vld;
  logic        accept;
  logic        fault;
  logic        inj;
  logic [3:0]  a_cur;
  logic [3:0]  b_cur;
  logic [1:0]  s_cur;
`ifdef ALU_FAULT_INJECT_EN
  assign inj = inject_i;
`else
  assign inj = 1'b0;
`endif
  // Internal reset asserts asynchronously but releases two clocks after wb_rst_n_i rises.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 3'(ptr) + 3'(k);
      idx = (idx >= 3'(NREQ)) ? idx - 3'(NREQ) : idx;
      if (1'(req_valid_i >> idx)) begin
        gnt_vld = 1'b1;
        gnt = idx[1:0];
      end
    end
  end
  assign a_cur = 4'(req_a_i >> {gnt, 2'b00});
  assign b_cur = 4'(req_b_i >> {gnt, 2'b00});
  assign s_cur = 2'(req_sel_i >> {gnt, 1'b0});
  assign accept = rst_n && state == IDLE && gnt_vld;
  assign req_ready_o = accept ? NREQ'(1) << gnt : '0;
  assign fault = (alu_out1_i != alu_out2_i) || (alu_carry1_i != alu_carry2_i);
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      alu_a0_o <= '0;
      alu_b0_o <= '0;
      alu_a1_o <= '0;
      alu_b1_o <= '0;
      alu_sel1_o <= '0;
      alu_sel2_o <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o <= '0;
      resp_result_o <= '0;
      resp_carry_o <= 1'b0;
      resp_fault_o <= 1'b0;
      fault_cnt_o <= '0;
      irq_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_a0_o <= a_cur;
          alu_a1_o <= a_cur ^ {3'b000, inj};
          alu_b0_o <= b_cur;
          alu_b1_o <= b_cur;
          alu_sel1_o <= s_cur;
          alu_sel2_o <= s_cur;
          resp_id_o <= gnt;
          ptr <= (gnt == 2'(NREQ - 1)) ? 2'd0 : gnt + 2'd1;
          cnt <= 3'(ALU_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          state <= (cnt == 3'd1) ? CHECK : WAIT;
        end
        CHECK: begin
          resp_result_o <= alu_out1_i;
          resp_carry_o <= alu_carry1_i;
          resp_fault_o <= fault;
          resp_valid_o <= 1'b1;
          state <= RESP;
        end
        default: if (resp_ready_i) begin
          resp_valid_o <= 1'b0;
          state <= IDLE;
        end
      endcase
      // A fault seen in the same cycle as a clear still counts as one.
      if (state == CHECK && fault) begin
        fault_cnt_o <= fault_clr_i ? FCNT_W'(1) : (&fault_cnt_o ? fault_cnt_o : fault_cnt_o + FCNT_W'(1));
        irq_o <= 1'b1;
      end else if (fault_clr_i) begin
        fault_cnt_o <= '0;
        irq_o <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_lockstep_sched.sv
// tb_alu_lockstep_sched: table, hand-written and random checks of alu_lockstep_sched against a reference model.
module tb_alu_lockstep_sched;
  localparam int NREQ = 2;
  localparam int ALU_LAT = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [7:0] req_a = '0, req_b = '0;
  logic [3:0] req_sel = '0;
  logic resp_ready = 1'b1, fault_clr = 1'b0, frc_mis = 1'b0, inj = 1'b0;
  logic [1:0] req_ready, resp_id, sel1, sel2;
  logic resp_valid, resp_carry, resp_fault, irq;
  logic [3:0] resp_result, a0, b0, a1, b1, out1, out2;
  logic carry1, carry2;
  logic [7:0] fault_cnt;
  logic [4:0] r1, r2;
  logic [1:0] d2_ready, d2_id, d2_s1, d2_s2, d2_cnt;
  logic d2_rv, d2_c, d2_f, d2_irq;
  logic [3:0] d2_res, d2_a0, d2_b0, d2_a1, d2_b1;
  int total = 0, fails = 0;
  int m_ptr = 0, exp_cnt = 0, exp_cnt2 = 0;
  logic exp_irq = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_ref(input logic [3:0] a, b, input logic [1:0] s);
    return s == 2'd0 ? {1'b0, a} + {1'b0, b} :
           s == 2'd1 ? {1'b0, a} - {1'b0, b} :
           s == 2'd2 ? {1'b0, a ^ b} : {1'b0, a & b};
  endfunction

  function automatic logic [1:0] rr(input logic [1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return 2'((p + k) % NREQ);
    return 2'd0;
  endfunction

  assign r1 = alu_ref(a0, b0, sel1);
  assign r2 = alu_ref(a1, b1, sel2);
  assign out1 = r1[3:0];
  assign carry1 = r1[4];
  assign out2 = r2[3:0] ^ {3'b000, frc_mis};
  assign carry2 = r2[4];

  alu_lockstep_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .FCNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
`ifdef ALU_FAULT_INJECT_EN
    .inject_i(inj),
`endif
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_sel_i(req_sel),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_result_o(resp_result), .resp_carry_o(resp_carry), .resp_fault_o(resp_fault),
    .alu_a0_o(a0), .alu_b0_o(b0), .alu_a1_o(a1), .alu_b1_o(b1), .alu_sel1_o(sel1), .alu_sel2_o(sel2),
    .alu_out1_i(out1), .alu_out2_i(out2), .alu_carry1_i(carry1), .alu_carry2_i(carry2),
    .fault_clr_i(fault_clr), .fault_cnt_o(fault_cnt), .irq_o(irq)
  );

  alu_lockstep_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .FCNT_W(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
`ifdef ALU_FAULT_INJECT_EN
    .inject_i(inj),
`endif
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_sel_i(req_sel),
    .req_ready_o(d2_ready), .resp_valid_o(d2_rv), .resp_ready_i(resp_ready),
    .resp_id_o(d2_id), .resp_result_o(d2_res), .resp_carry_o(d2_c), .resp_fault_o(d2_f),
    .alu_a0_o(d2_a0), .alu_b0_o(d2_b0), .alu_a1_o(d2_a1), .alu_b1_o(d2_b1), .alu_sel1_o(d2_s1), .alu_sel2_o(d2_s2),
    .alu_out1_i(out1), .alu_out2_i(out2), .alu_carry1_i(carry1), .alu_carry2_i(carry2),
    .fault_clr_i(fault_clr), .fault_cnt_o(d2_cnt), .irq_o(d2_irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic op(input logic [1:0] v, input logic [7:0] a, b, input logic [3:0] s,
                    input logic frc, clr, input int hold, input logic [1:0] post,
                    input logic [1:0] eid, input logic [3:0] eres, input logic ec, ef);
    int n;
    logic [3:0] ea, eb;
    logic [1:0] es;
    ea = 4'(a >> (4 * eid));
    eb = 4'(b >> (4 * eid));
    es = 2'(s >> (2 * eid));
    req_valid = v; req_a = a; req_b = b; req_sel = s; frc_mis = frc;
    if (hold > 0) resp_ready = 1'b0;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    chk("grant", req_ready, 2'b01 << eid);
    @(posedge clk); #1;
    req_valid = post;
    chk("alu_a0", a0, ea);
    chk("alu_a1", a1, ea ^ {3'b000, inj});
    chk("alu_b", {b0, b1}, {eb, eb});
    chk("alu_sel", {sel1, sel2}, {es, es});
    n = 0;
    while (!resp_valid && n < 20) begin
      fault_clr = clr && n == ALU_LAT;
      @(posedge clk); #1;
      n++;
    end
    fault_clr = 1'b0;
    chk("latency", n, ALU_LAT + 1);
    m_ptr = (eid + 1) % NREQ;
    if (ef) begin
      exp_cnt = clr ? 1 : (exp_cnt == 255 ? 255 : exp_cnt + 1);
      exp_cnt2 = clr ? 1 : (exp_cnt2 == 3 ? 3 : exp_cnt2 + 1);
      exp_irq = 1'b1;
    end
    chk("resp_id", resp_id, eid);
    chk("resp_result", resp_result, eres);
    chk("resp_carry", resp_carry, ec);
    chk("resp_fault", resp_fault, ef);
    chk("fault_cnt", fault_cnt, exp_cnt);
    chk("fault_cnt_w2", d2_cnt, exp_cnt2);
    chk("irq", irq, exp_irq);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_result", {resp_id, resp_result, resp_fault}, {eid, eres, ef});
      chk("hold_ready", req_ready, 2'b00);
      chk("hold_alu", {a0, b0, sel1}, {ea, eb, es});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    frc_mis = 1'b0;
  endtask

  task automatic clear();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    exp_cnt = 0; exp_cnt2 = 0; exp_irq = 1'b0;
    chk("clr_cnt", fault_cnt, 0);
    chk("clr_irq", irq, 1'b0);
  endtask

  typedef struct {
    logic [1:0] v; logic [7:0] a, b; logic [3:0] s; logic frc;
    logic [1:0] id; logic [3:0] res; logic c, f;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    logic [1:0] v, eid;
    logic [7:0] a, b;
    logic [3:0] s;
    logic frc;
    logic [4:0] r;
    tbl[0] = '{2'b01, 8'h03, 8'h05, 4'h0, 1'b0, 2'd0, 4'h8, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 8'h90, 8'h80, 4'h0, 1'b0, 2'd1, 4'h1, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 8'h47, 8'h21, 4'h5, 1'b0, 2'd0, 4'h6, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 8'h47, 8'h21, 4'h5, 1'b0, 2'd1, 4'h2, 1'b0, 1'b0};
    tbl[4] = '{2'b11, 8'hCA, 8'h56, 4'hB, 1'b0, 2'd0, 4'h2, 1'b0, 1'b0};
    tbl[5] = '{2'b11, 8'hCA, 8'h56, 4'hB, 1'b0, 2'd1, 4'h9, 1'b0, 1'b0};
    tbl[6] = '{2'b01, 8'h02, 8'h03, 4'h1, 1'b0, 2'd0, 4'hF, 1'b1, 1'b0};
    tbl[7] = '{2'b01, 8'h01, 8'h01, 4'h0, 1'b1, 2'd0, 4'h2, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_outputs", {resp_valid, req_ready, a0, a1, b0, sel1, resp_id, resp_result, resp_fault}, 0);
    chk("rst_cnt_irq", {fault_cnt, irq}, 0);
    rst_n = 1'b1;

    req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05; req_sel = 4'h0;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    chk("pre_rst_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("pre_rst_alu", a0, 4'h3);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_outputs", {resp_valid, req_ready, a0, a1, b0, b1, sel1, sel2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= resp_valid; end
    chk("no_resp_after_rst", seen, 1'b0);
    m_ptr = 0;

    for (int i = 0; i < 8; i++)
      op(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].frc, 1'b0, 0, 2'b00,
         tbl[i].id, tbl[i].res, tbl[i].c, tbl[i].f);
    clear();

    op(2'b01, 8'h24, 8'h13, 4'h0, 1'b0, 1'b0, 5, 2'b10, 2'd0, 4'h7, 1'b0, 1'b0);
    #1;
    chk("req1_after_release", req_ready, 2'b10);
    op(2'b10, 8'h24, 8'h13, 4'h0, 1'b0, 1'b0, 0, 2'b00, 2'd1, 4'h3, 1'b0, 1'b0);

    op(2'b01, 8'h01, 8'h02, 4'h0, 1'b1, 1'b0, 0, 2'b00, 2'd0, 4'h3, 1'b0, 1'b1);
    op(2'b01, 8'h01, 8'h02, 4'h0, 1'b1, 1'b1, 0, 2'b00, 2'd0, 4'h3, 1'b0, 1'b1);
    chk("coincident_clr", {fault_cnt, irq}, {8'd1, 1'b1});
    clear();

    for (int i = 0; i < 5; i++)
      op(2'b01, 8'h01, 8'h02, 4'h0, 1'b1, 1'b0, 0, 2'b00, 2'd0, 4'h3, 1'b0, 1'b1);
    chk("saturate_w2", d2_cnt, 2'd3);
    chk("count_w8", fault_cnt, 8'd5);
    clear();

`ifdef ALU_FAULT_INJECT_EN
    inj = 1'b1;
    op(2'b01, 8'h06, 8'h00, 4'h2, 1'b0, 1'b0, 0, 2'b00, rr(2'b01, m_ptr), 4'h6, 1'b0, 1'b1);
    inj = 1'b0;
    clear();
`endif

    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      s = 4'($urandom);
      frc = $urandom_range(0, 7) == 0;
      eid = rr(v, m_ptr);
      r = alu_ref(4'(a >> (4 * eid)), 4'(b >> (4 * eid)), 2'(s >> (2 * eid)));
      op(v, a, b, s, frc, 1'b0, 0, 2'b00, eid, r[3:0], r[4], frc);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
